// File: rtl/mydesign_bist_pkg.sv
// Shared types and helpers for the mydesign_bist self-test block.
package mydesign_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // Number of (operand_a, operand_b) pairs in one exhaustive sweep.
  function automatic int n_vec(input int n_in);
    return 1 << (2 * n_in);
  endfunction

endpackage

// File: rtl/mydesign_bist_golden.sv
// Combinational reference adder: unsigned a + b truncated to N_OUT bits.
module mydesign_bist_golden #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3
) (
  input  logic [N_IN-1:0]  a,
  input  logic [N_IN-1:0]  b,
  output logic [N_OUT-1:0] sum
);

  // Wide enough for the carry and for any N_OUT wider than the operands.
  localparam int SW = (N_IN + 1 > N_OUT) ? N_IN + 1 : N_OUT;

  assign sum = N_OUT'(SW'(a) + SW'(b));

endmodule

// File: rtl/mydesign_bist.sv
// Exhaustive self-test driver/checker for the registered adder.
// Optional first-mismatch capture ports: define MYDESIGN_BIST_FIRST_FAIL_EN.
module mydesign_bist
  import mydesign_bist_pkg::*;
#(
  parameter int N_IN      = 3,
  parameter int N_OUT     = 3,
  parameter int DUT_LAT   = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_ci,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic [N_IN-1:0]      operand_a_o,
  output logic [N_IN-1:0]      operand_b_o,
  input  logic [N_OUT-1:0]     result_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_count_o
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]      first_fail_a_o,
  output logic [N_IN-1:0]      first_fail_b_o,
  output logic [N_OUT-1:0]     first_fail_res_o
`endif
);

  localparam int NV = n_vec(N_IN);
  localparam int VW = 2 * N_IN;

  // One entry travels alongside each driven vector until its result returns.
  typedef struct packed {
    logic             vld;
    logic [N_OUT-1:0] exp;
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    logic [N_IN-1:0]  a;
    logic [N_IN-1:0]  b;
`endif
  } pipe_entry_t;

  bist_state_e          state_q, state_d;
  logic [VW-1:0]        vec_q;
  logic [VW-1:0]        vec_nxt;
  logic                 last_vec;
  logic                 launch;
  logic                 pipe_busy;
  logic                 mismatch;
  logic [N_OUT-1:0]     golden_sum;
  pipe_entry_t          new_entry;
  pipe_entry_t          pipe_q [DUT_LAT];
  logic [ERR_CNT_W-1:0] err_q;

  mydesign_bist_golden #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_golden (
    .a   (operand_a_o),
    .b   (operand_b_o),
    .sum (golden_sum)
  );

  assign vec_nxt  = vec_q + VW'(1);
  assign last_vec = (vec_q == VW'(NV - 1));
  assign launch   = start_i && ((state_q == IDLE) || (state_q == DONE));

  // Entries still in flight that have not yet reached the compare stage.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < DUT_LAT - 1; i++) begin
      pipe_busy = pipe_busy | pipe_q[i].vld;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = DRIVE;
      DRIVE:   if (last_vec) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    if (start_i) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Operands hold the vector currently being applied; zero outside DRIVE.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q       <= '0;
      operand_a_o <= '0;
      operand_b_o <= '0;
    end else if (launch) begin
      vec_q       <= '0;
      operand_a_o <= '0;
      operand_b_o <= '0;
    end else if (state_q == DRIVE) begin
      vec_q <= vec_nxt;
      if (last_vec) begin
        operand_a_o <= '0;
        operand_b_o <= '0;
      end else begin
        {operand_a_o, operand_b_o} <= vec_nxt;
      end
    end
  end

  always_comb begin
    new_entry     = '0;
    new_entry.vld = (state_q == DRIVE);
    new_entry.exp = golden_sum;
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    new_entry.a   = operand_a_o;
    new_entry.b   = operand_b_o;
`endif
  end

  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DUT_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= new_entry;
      for (int i = 1; i < DUT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // result_i is only looked at while the aligned entry is valid.
  assign mismatch = pipe_q[DUT_LAT-1].vld && (result_i != pipe_q[DUT_LAT-1].exp);

  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni)                     err_q <= '0;
    else if (launch)                 err_q <= '0;
    else if (mismatch && err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
  end

`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
  // Capture happens only while the error count is still zero for this sweep.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni || 1'b0) begin
      first_fail_a_o   <= '0;
      first_fail_b_o   <= '0;
      first_fail_res_o <= '0;
    end else if (launch) begin
      first_fail_a_o   <= '0;
      first_fail_b_o   <= '0;
      first_fail_res_o <= '0;
    end else if (mismatch && err_q == '0) begin
      first_fail_a_o   <= pipe_q[DUT_LAT-1].a;
      first_fail_b_o   <= pipe_q[DUT_LAT-1].b;
      first_fail_res_o <= result_i;
    end
  end
`endif

  assign busy_o      = (state_q == DRIVE) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign pass_o      = done_o && (err_q == '0);
  assign err_count_o = err_q;

endmodule

// File: tb/tb_mydesign_bist.sv
// Self-checking bench for mydesign_bist: ideal, faulty and latency-mismatched adder models.
module tb_mydesign_bist;
  import mydesign_bist_pkg::*;

  localparam int NV = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   mode_r;
  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic [5:0] exp_q[$];

  // ---------------- main instance: DUT_LAT=1, ERR_CNT_W=8 ----------------
  logic [2:0] m_a, m_b, m_res, m_r1;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_err;
  always @(posedge clk) m_r1 <= m_a + m_b;
  assign m_res = (mode_r == 1) ? (m_r1 & 3'b110) : (mode_r == 2) ? ~m_r1 : m_r1;
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
  logic [2:0] m_ffa, m_ffb, m_ffr;
`endif

  mydesign_bist u_dut (
    .clk_ci(clk), .rst_ni(rst_n), .start_i(start),
    .operand_a_o(m_a), .operand_b_o(m_b), .result_i(m_res),
    .busy_o(m_busy), .done_o(m_done), .pass_o(m_pass), .err_count_o(m_err)
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    , .first_fail_a_o(m_ffa), .first_fail_b_o(m_ffb), .first_fail_res_o(m_ffr)
`endif
  );

  // ---------------- ERR_CNT_W=4 with fully inverted result ----------------
  logic [2:0] w_a, w_b, w_r1;
  logic       w_busy, w_done, w_pass;
  logic [3:0] w_err;
  always @(posedge clk) w_r1 <= w_a + w_b;
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
  logic [2:0] w_ffa, w_ffb, w_ffr;
`endif

  mydesign_bist #(.ERR_CNT_W(4)) u_dut_w4 (
    .clk_ci(clk), .rst_ni(rst_n), .start_i(start),
    .operand_a_o(w_a), .operand_b_o(w_b), .result_i(~w_r1),
    .busy_o(w_busy), .done_o(w_done), .pass_o(w_pass), .err_count_o(w_err)
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    , .first_fail_a_o(w_ffa), .first_fail_b_o(w_ffb), .first_fail_res_o(w_ffr)
`endif
  );

  // ---------------- DUT_LAT=2 with a matching 2-stage adder ----------------
  logic [2:0] l_a, l_b, l_s1, l_s2;
  logic       l_busy, l_done, l_pass;
  logic [7:0] l_err;
  always @(posedge clk) begin
    l_s1 <= l_a + l_b;
    l_s2 <= l_s1;
  end
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
  logic [2:0] l_ffa, l_ffb, l_ffr;
`endif

  mydesign_bist #(.DUT_LAT(2)) u_dut_l2 (
    .clk_ci(clk), .rst_ni(rst_n), .start_i(start),
    .operand_a_o(l_a), .operand_b_o(l_b), .result_i(l_s2),
    .busy_o(l_busy), .done_o(l_done), .pass_o(l_pass), .err_count_o(l_err)
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    , .first_fail_a_o(l_ffa), .first_fail_b_o(l_ffb), .first_fail_res_o(l_ffr)
`endif
  );

  // ---------------- DUT_LAT=2 wrongly paired with a 1-stage adder ----------------
  logic [2:0] k_a, k_b, k_r1;
  logic       k_busy, k_done, k_pass;
  logic [7:0] k_err;
  always @(posedge clk) k_r1 <= k_a + k_b;
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
  logic [2:0] k_ffa, k_ffb, k_ffr;
`endif

  mydesign_bist #(.DUT_LAT(2)) u_dut_l2b (
    .clk_ci(clk), .rst_ni(rst_n), .start_i(start),
    .operand_a_o(k_a), .operand_b_o(k_b), .result_i(k_r1),
    .busy_o(k_busy), .done_o(k_done), .pass_o(k_pass), .err_count_o(k_err)
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    , .first_fail_a_o(k_ffa), .first_fail_b_o(k_ffb), .first_fail_res_o(k_ffr)
`endif
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of a full sweep against an adder fault mode.
  task automatic model_sweep(input int mode, input int w, output int err,
                             output int fa, output int fb, output int fr);
    int s, r;
    err = 0; fa = 0; fb = 0; fr = 0;
    for (int v = 0; v < NV; v++) begin
      s = ((v >> 3) + (v & 7)) % 8;
      r = (mode == 1) ? (s & 6) : (mode == 2) ? ((~s) & 7) : s;
      if (r != s) begin
        if (err == 0) begin fa = v >> 3; fb = v & 7; fr = r; end
        if (err < (1 << w) - 1) err++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input int mode, input bit extra_starts);
    int done_i, l_done_i, busy_n, e_err, e_fa, e_fb, e_fr;
    logic [5:0] e;
    mode_r = mode;
    model_sweep(mode, 8, e_err, e_fa, e_fb, e_fr);
    start = 1'b1;
    for (int v = 0; v < NV; v++) exp_q.push_back(6'(v));
    done_i = -1; l_done_i = -1; busy_n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      start = extra_starts && (i == 10 || i == 64);
      if (m_busy) busy_n++;
      if (i < NV) begin
        if (exp_q.size() == 0) check_eq("scoreboard_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("operands", {26'd0, m_a, m_b}, {26'd0, e});
        end
      end else if (i == NV) begin
        check_eq("drain_operands_zero", {26'd0, m_a, m_b}, 0);
      end
      if (m_done && done_i < 0) done_i = i;
      if (l_done && l_done_i < 0) l_done_i = i;
    end
    start = 1'b0;
    check_eq("done_edge", done_i, NV + 1);
    check_eq("busy_cycles", busy_n, NV + 1);
    check_eq("done_held", m_done, 1);
    check_eq("idle_operands_zero", {26'd0, m_a, m_b}, 0);
    check_eq("err_count", m_err, e_err);
    check_eq("pass", m_pass, (e_err == 0));
`ifdef MYDESIGN_BIST_FIRST_FAIL_EN
    check_eq("first_fail_a", m_ffa, e_fa);
    check_eq("first_fail_b", m_ffb, e_fb);
    check_eq("first_fail_res", m_ffr, e_fr);
`endif
    check_eq("w4_err_saturated", w_err, 15);
    check_eq("w4_pass", w_pass, 0);
    check_eq("lat2_done_edge", l_done_i, NV + 2);
    check_eq("lat2_pass", l_pass, 1);
    check_eq("lat2_err", l_err, 0);
    check_eq("lat2_short_dut_err_nonzero", (k_err != 0), 1);
    check_eq("lat2_short_dut_pass", k_pass, 0);
  endtask

  task automatic abort_sweep();
    mode_r = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check_eq("pre_abort_busy", m_busy, 1);
    check_eq("pre_abort_err_nonzero", (m_err != 0), 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", m_busy, 0);
    check_eq("abort_done", m_done, 0);
    check_eq("abort_pass", m_pass, 0);
    check_eq("abort_err", m_err, 0);
    check_eq("abort_operands", {26'd0, m_a, m_b}, 0);
    check_eq("abort_state", 32'(u_dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_abort_idle_busy", m_busy, 0);
    check_eq("post_abort_idle_done", m_done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode_r = 0;
    #1;
    check_eq("reset_busy", m_busy, 0);
    check_eq("reset_done", m_done, 0);
    check_eq("reset_pass", m_pass, 0);
    check_eq("reset_err", m_err, 0);
    check_eq("reset_operands", {26'd0, m_a, m_b}, 0);
    check_eq("reset_state", 32'(u_dut.state_q), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(0, 1'b1);
    run_sweep(0, 1'b0);
    abort_sweep();
    run_sweep(0, 1'b0);
    run_sweep(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
